// File: rtl/soin_trace_pkg.sv
// Shared retirement-record layout for the commit trace port
// and anything that decodes its records.
package soin_trace_pkg;

    typedef struct packed {
        logic [31:0] seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rd_we;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
    } trace_rec_t;

    localparam int TRACE_REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with a registered first-word-fall-through
// head; full/empty come from the occupancy counter.
module trace_fifo
    import soin_trace_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = trace_rec_t,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_push,
    input  T              i_data,
    input  logic          i_pop,
    output logic          o_push_ok,
    output logic          o_drop,
    output logic          o_valid,
    output T              o_head,
    output logic [LW-1:0] o_level,
    output logic [LW-1:0] o_level_nxt
);

    T              mem [DEPTH];
    T              head_nxt;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] rptr_nxt;
    logic          full;
    logic          empty;
    logic          pop_ok;

    assign full      = (o_level == LW'(DEPTH));
    assign empty     = (o_level == '0);
    assign pop_ok    = i_pop && !empty;
    assign o_push_ok = i_push && (!full || pop_ok);
    assign o_drop    = i_push && !o_push_ok;
    assign rptr_nxt  = pop_ok ? rptr + 1'b1 : rptr;

    always_comb begin
        o_level_nxt = o_level;
        if (o_push_ok && !pop_ok) begin
            o_level_nxt = o_level + 1'b1;
        end else if (!o_push_ok && pop_ok) begin
            o_level_nxt = o_level - 1'b1;
        end
    end

    // The new head is the incoming record only when it lands in the slot
    // the read pointer moves to, i.e. the FIFO holds just that one record.
    always_comb begin
        head_nxt = o_head;
        if (o_level_nxt != '0) begin
            if (o_push_ok && (wptr == rptr_nxt)) begin
                head_nxt = i_data;
            end else begin
                head_nxt = mem[rptr_nxt];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (o_push_ok) begin
            mem[wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wptr    <= '0;
            rptr    <= '0;
            o_level <= '0;
            o_valid <= 1'b0;
            o_head  <= '0;
        end else begin
            if (o_push_ok) begin
                wptr <= wptr + 1'b1;
            end
            rptr    <= rptr_nxt;
            o_level <= o_level_nxt;
            o_valid <= (o_level_nxt != '0);
            o_head  <= head_nxt;
        end
    end

endmodule

// File: rtl/commit_trace_port.sv
// Per-instruction retirement trace: numbers commits, buffers them and
// offers them over valid/ready with early back-pressure and drop counting.
module commit_trace_port
    import soin_trace_pkg::*;
#(
    parameter int  DEPTH       = 8,
    parameter int  ALMOST_FULL = 6,
    parameter int  CNT_W       = 16,
    localparam int LW          = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_commit_valid,
    input  logic [31:0]      i_commit_pc,
    input  logic [31:0]      i_commit_instr,
    input  logic             i_commit_rd_we,
    input  logic [4:0]       i_commit_rd_addr,
    input  logic [31:0]      i_commit_rd_data,
    output logic             o_stall_req,
    output logic             o_trace_valid,
    input  logic             i_trace_ready,
    output logic [31:0]      o_trace_seq,
    output logic [31:0]      o_trace_pc,
    output logic [31:0]      o_trace_instr,
    output logic             o_trace_rd_we,
    output logic [4:0]       o_trace_rd_addr,
    output logic [31:0]      o_trace_rd_data,
    output logic [LW-1:0]    o_level,
    output logic             o_overflow,
    output logic [CNT_W-1:0] o_drop_count
);

    trace_rec_t    rec_in;
    trace_rec_t    head;
    logic [31:0]   seq_cnt;
    logic          push_ok;
    logic          drop;
    logic [LW-1:0] level_nxt;

    always_comb begin
        rec_in         = '0;
        rec_in.seq     = seq_cnt;
        rec_in.pc      = i_commit_pc;
        rec_in.instr   = i_commit_instr;
        rec_in.rd_we   = i_commit_rd_we && (i_commit_rd_addr != 5'd0);
        rec_in.rd_addr = i_commit_rd_addr;
        rec_in.rd_data = i_commit_rd_data;
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .T     (trace_rec_t)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_push      (i_commit_valid),
        .i_data      (rec_in),
        .i_pop       (i_trace_ready),
        .o_push_ok   (push_ok),
        .o_drop      (drop),
        .o_valid     (o_trace_valid),
        .o_head      (head),
        .o_level     (o_level),
        .o_level_nxt (level_nxt)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            seq_cnt      <= '0;
            o_overflow   <= 1'b0;
            o_drop_count <= '0;
            o_stall_req  <= 1'b0;
        end else begin
            if (push_ok) begin
                seq_cnt <= seq_cnt + 32'd1;
            end
            if (drop) begin
                o_overflow <= 1'b1;
                if (o_drop_count != '1) begin
                    o_drop_count <= o_drop_count + 1'b1;
                end
            end
            o_stall_req <= (level_nxt >= LW'(ALMOST_FULL));
        end
    end

    assign o_trace_seq     = head.seq;
    assign o_trace_pc      = head.pc;
    assign o_trace_instr   = head.instr;
    assign o_trace_rd_we   = head.rd_we;
    assign o_trace_rd_addr = head.rd_addr;
    assign o_trace_rd_data = head.rd_data;

endmodule
